mem_request_sequencer: RTL and testbench
========================================

Name: mem_request_sequencer

Overview:
- Sits directly upstream of memoryModule and is the processor's only path to data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and buffers them in a small request FIFO.
- Replays each request to memoryModule by driving cntrl/addr/dataIn/isIndirect and holding them stable until dataReady.
- Returns one response per request; a watchdog flags a memory access that never completes.

Parameters:
- ramWidth, 8, data word width; must match memoryModule.
- addrSize, 8, address width; must match memoryModule.
- fifoDepth, 2, request FIFO entries; power of two, at least 2.
- timeoutCycles, 64, maximum cycles spent waiting for memDataReady before error.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  FIFO can accept; equals not-full.
- reqWrite  in  1  1 = store, 0 = load.
- reqIndirect  in  1  indirect addressing; forwarded to memIsIndirect.
- reqAddr  in  addrSize  request address.
- reqData  in  ramWidth  store data.
- respValid  out  1  one-cycle response pulse.
- respData  out  ramWidth  load result; 0 for stores and errors.
- respError  out  1  qualified by respValid; timeout occurred.
- memCntrl  out  2  to memoryModule cntrl: 00 idle, 01 read, 10 write, 11 never driven.
- memAddr  out  addrSize  to memoryModule addr.
- memDataIn  out  ramWidth  to memoryModule dataIn.
- memIsIndirect  out  1  to memoryModule isIndirect.
- memDataOut  in  ramWidth  from memoryModule dataOut.
- memDataReady  in  1  from memoryModule dataReady.

Behaviour:
- Clock/reset: one clock, clk. Reset clr is synchronous and active-high.
- Reset values: memCntrl=00, memAddr=0, memDataIn=0, memIsIndirect=0, respValid=0, respData=0, respError=0, FIFO empty (reqReady=1), timeout counter 0, state IDLE.
- Push: occurs at an edge where reqValid and reqReady are both 1. The entry stores {write, indirect, addr, data}.
- reqReady is registered from FIFO count. There is no bypass while full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both take effect; count unchanged.
- FIFO pointers wrap modulo fifoDepth.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head and register memAddr, memDataIn and memIsIndirect.
  - Set memCntrl to 10 for a store or 01 for a load; go to ISSUE.
  - Minimum latency: a push at edge N gives the pop at edge N+1 and memCntrl valid in the cycle after N+1.
- ISSUE: lasts one cycle; clears the timeout counter; go to WAIT.
- WAIT:
  - memCntrl, memAddr, memDataIn and memIsIndirect are held stable.
  - The counter increments each cycle.
  - If memDataReady=1: capture memDataOut into respData for a load (0 for a store), set memCntrl=00, go to RESP.
  - Else if counter reaches timeoutCycles-1: respData=0, respError=1, memCntrl=00, go to RESP.
  - If memDataReady and the timeout coincide, memDataReady wins and there is no error.
- RESP: respValid=1 for exactly one cycle, then return to IDLE.
  - memCntrl is 00 for at least this cycle, so memoryModule sees a gap between back-to-back requests.
- Consequences: respValid is never asserted on two consecutive cycles, and responses come back in request order.
- memDataReady in IDLE, ISSUE or RESP is ignored.
- respError clears to 0 on the cycle after RESP.
- clr mid-operation:
  - The in-flight access is abandoned with no response, all queued requests are dropped, and outputs return to reset values at that edge.
  - The upstream stage must reissue.

Decomposition:
- Shared package mem_seq_pkg holds:
  - memCntrl encodings: MEM_IDLE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10.
  - FSM state encodings.
  - The request-entry field layout, width 2+addrSize+ramWidth.
- One sub-module, req_fifo: a synchronous FIFO parameterised by width and depth, with push/pop/full/empty and synchronous clr.
- The FSM, timeout counter and output registers live in mem_request_sequencer.

Test Plan (all cases use ramWidth=8, addrSize=8):
- Single load: push {load, addr=0x12}; model returns 0xA5 with memDataReady 3 cycles into WAIT -> memCntrl=01 and memAddr=0x12 held throughout WAIT, then one respValid pulse with respData=0xA5, respError=0.
- Single store: push {store, addr=0x40, data=0x3C} -> memCntrl=10, memDataIn=0x3C held until ready; respValid with respData=0x00; memCntrl returns to 00 in RESP.
- Back-to-back with FIFO fill:
  - Push 3 loads (addr 0x01, 0x02, 0x03) on consecutive cycles while the memory stalls -> reqReady drops after the FIFO fills.
  - Responses arrive in order 0x01→0x02→0x03, with at least one memCntrl=00 cycle between accesses.
- Timeout: memDataReady tied low -> after 64 WAIT cycles respValid=1, respError=1, respData=0; the next queued request then issues normally.
- Indirect passthrough: push {load, indirect=1, addr=0x08} -> memIsIndirect=1 for the whole access; respData equals the model's dereferenced value 0x77.
- Reset mid-access: assert clr in WAIT with 1 request queued -> the next cycle has memCntrl=00, reqReady=1 and no respValid; a new request afterwards completes correctly.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared encodings and request-entry layout for mem_request_sequencer
package mem_seq_pkg;
  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  localparam int ENTRY_WRITE_FROM_MSB = 0;
  localparam int ENTRY_INDIRECT_FROM_MSB = 1;
  function automatic int entry_width(input int addr_size, input int ram_width);
    return 2 + addr_size + ram_width;
  endfunction
endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous power-of-two FIFO with show-ahead head and synchronous clear
module req_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CNTW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer: queues load/store requests and replays them one at a time to memoryModule
module mem_request_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ramWidth = 8,
  parameter int addrSize = 8,
  parameter int fifoDepth = 2,
  parameter int timeoutCycles = 64
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic                reqIndirect,
  input  logic [addrSize-1:0] reqAddr,
  input  logic [ramWidth-1:0] reqData,
  output logic                respValid,
  output logic [ramWidth-1:0] respData,
  output logic                respError,
  output logic [1:0]          memCntrl,
  output logic [addrSize-1:0] memAddr,
  output logic [ramWidth-1:0] memDataIn,
  output logic                memIsIndirect,
  input  logic [ramWidth-1:0] memDataOut,
  input  logic                memDataReady
);
  localparam int EW = entry_width(addrSize, ramWidth);
  localparam int CW = $clog2(timeoutCycles);
  seq_state_t state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [EW-1:0] head;
  logic full, empty, push, pop, timed_out;
  assign push = reqValid && !full;
  assign pop = state == IDLE && !empty;
  assign reqReady = !full;
  assign respValid = state == RESP;
  assign timed_out = wait_cnt == CW'(timeoutCycles - 1);
  req_fifo #(.WIDTH(EW), .DEPTH(fifoDepth)) u_fifo (
    .clk(clk),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din({reqWrite, reqIndirect, reqAddr, reqData}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (empty ? IDLE : ISSUE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? (memDataReady || timed_out ? RESP : WAIT) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      wait_cnt <= '0;
      memCntrl <= MEM_IDLE;
      memAddr <= '0;
      memDataIn <= '0;
      memIsIndirect <= 1'b0;
      respData <= '0;
      respError <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        memCntrl <= head[EW-1-ENTRY_WRITE_FROM_MSB] ? MEM_WRITE : MEM_READ;
        memIsIndirect <= head[EW-1-ENTRY_INDIRECT_FROM_MSB];
        memAddr <= head[ramWidth +: addrSize];
        memDataIn <= head[ramWidth-1:0];
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (memDataReady) begin
          respData <= memCntrl == MEM_WRITE ? '0 : memDataOut;
          respError <= 1'b0;
          memCntrl <= MEM_IDLE;
        end else if (timed_out) begin
          respData <= '0;
          respError <= 1'b1;
          memCntrl <= MEM_IDLE;
        end
      end
      if (state == RESP) respError <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb_mem_request_sequencer: table, directed and random checks against an in-order request/memory model
module tb_mem_request_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic reqValid = 1'b0, reqWrite = 1'b0, reqIndirect = 1'b0;
  logic [7:0] reqAddr = '0, reqData = '0;
  logic reqReady, respValid, respError, memIsIndirect;
  logic [7:0] respData, memAddr, memDataIn;
  logic [1:0] memCntrl;
  logic [7:0] memDataOut;
  logic memDataReady;

  typedef struct {
    logic w, ind, err;
    logic [7:0] a, d, data;
  } resp_t;
  typedef struct {
    logic w, ind;
    logic [7:0] a, d;
    int lat;
    logic [7:0] exp_data;
  } vec_t;

  resp_t exp_q[$];
  logic [7:0] ram [256];
  logic [7:0] ref_ram [256];
  int checks = 0, errors = 0;
  int lat = 3, cyc = 0, issue_cyc = 0;
  logic stall = 1'b0, noise = 1'b0;

  mem_request_sequencer dut (
    .clk(clk), .clr(clr),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqIndirect(reqIndirect),
    .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respError(respError),
    .memCntrl(memCntrl), .memAddr(memAddr), .memDataIn(memDataIn), .memIsIndirect(memIsIndirect),
    .memDataOut(memDataOut), .memDataReady(memDataReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic w, input logic ind, input logic [7:0] a, input logic [7:0] d, input logic to);
    resp_t e;
    logic [7:0] ea;
    int n = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqIndirect = ind; reqAddr = a; reqData = d;
    while (!reqReady && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", 32'(reqReady), 1);
    ea = ind ? ref_ram[a] : a;
    e.w = w; e.ind = ind; e.a = a; e.d = d; e.err = to;
    e.data = (w || to) ? 8'h00 : ref_ram[ea];
    if (w && !to) ref_ram[ea] = d;
    if (reqReady) exp_q.push_back(e);
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic wait_resp(output logic [7:0] d, output logic e, output int rc);
    logic ok = 1'b0;
    d = '0; e = 1'b0; rc = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (respValid) begin
        ok = 1'b1; d = respData; e = respError; rc = cyc;
      end
    end
    chk("resp_seen", 32'(ok), 1);
  endtask

  initial begin
    int rcnt = 0;
    logic [7:0] ea;
    memDataReady = 1'b0;
    memDataOut = '0;
    forever begin
      @(negedge clk);
      if (memCntrl == 2'b00) begin
        rcnt = 0;
        memDataReady = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        memDataOut = 8'($urandom);
      end else begin
        rcnt++;
        if (rcnt >= lat && !stall) begin
          ea = memIsIndirect ? ram[memAddr] : memAddr;
          memDataReady = 1'b1;
          memDataOut = 8'($urandom);
          if (memCntrl == 2'b10) ram[ea] = memDataIn;
          else memDataOut = ram[ea];
        end else begin
          memDataReady = 1'b0;
          memDataOut = 8'($urandom);
        end
      end
    end
  end

  initial begin
    resp_t f;
    logic prev_v = 1'b0;
    logic [1:0] prev_c = 2'b00;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_v = 1'b0;
        prev_c = 2'b00;
      end else begin
        chk("cntrl_legal", 32'(memCntrl == 2'b11), 0);
        if (memCntrl != 2'b00) begin
          if (prev_c == 2'b00) issue_cyc = cyc;
          chk("access_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk("access_cntrl", 32'(memCntrl), f.w ? 2 : 1);
            chk("access_addr", 32'(memAddr), 32'(f.a));
            chk("access_datain", 32'(memDataIn), 32'(f.d));
            chk("access_indirect", 32'(memIsIndirect), 32'(f.ind));
          end
        end
        if (respValid) begin
          chk("resp_gap", 32'(prev_v), 0);
          chk("resp_cntrl_idle", 32'(memCntrl), 0);
          chk("resp_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            chk("resp_data", 32'(respData), 32'(f.data));
            chk("resp_error", 32'(respError), 32'(f.err));
          end
        end
        prev_v = respValid;
        prev_c = memCntrl;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] rd;
    logic re;
    int rc;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i) ^ 8'hC3;
    end
    ram[8'h12] = 8'hA5;
    ram[8'h08] = 8'h50;
    ram[8'h50] = 8'h77;
    ref_ram = ram;
    tbl[0] = '{1'b0, 1'b0, 8'h12, 8'h00, 4, 8'hA5};
    tbl[1] = '{1'b1, 1'b0, 8'h40, 8'h3C, 5, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 8'h08, 8'h00, 3, 8'h77};
    tbl[3] = '{1'b0, 1'b0, 8'h40, 8'h00, 2, 8'h3C};
    tbl[4] = '{1'b1, 1'b1, 8'h08, 8'h99, 3, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 8'h50, 8'h00, 6, 8'h99};
    tbl[6] = '{1'b0, 1'b0, 8'h33, 8'h00, 65, 8'hF0};
    tbl[7] = '{1'b0, 1'b0, 8'h34, 8'h00, 64, 8'hF7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cntrl", 32'(memCntrl), 0);
    chk("rst_addr", 32'(memAddr), 0);
    chk("rst_datain", 32'(memDataIn), 0);
    chk("rst_indirect", 32'(memIsIndirect), 0);
    chk("rst_ready", 32'(reqReady), 1);
    chk("rst_valid", 32'(respValid), 0);
    chk("rst_data", 32'(respData), 0);
    chk("rst_error", 32'(respError), 0);
    clr = 1'b0;

    lat = 4;
    send(1'b0, 1'b0, 8'h12, 8'h00, 1'b0);
    @(negedge clk);
    chk("lat_still_idle", 32'(memCntrl), 0);
    @(negedge clk);
    chk("lat_cntrl_read", 32'(memCntrl), 1);
    chk("lat_addr", 32'(memAddr), 'h12);
    wait_resp(rd, re, rc);
    chk("single_load_data", 32'(rd), 'hA5);
    chk("single_load_err", 32'(re), 0);

    for (int i = 0; i < 8; i++) begin
      lat = tbl[i].lat;
      send(tbl[i].w, tbl[i].ind, tbl[i].a, tbl[i].d, 1'b0);
      wait_resp(rd, re, rc);
      chk($sformatf("vec%0d_data", i), 32'(rd), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_err", i), 32'(re), 0);
    end

    lat = 10;
    send(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
    send(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
    send(1'b0, 1'b0, 8'h03, 8'h00, 1'b0);
    @(negedge clk);
    chk("fill_ready_low", 32'(reqReady), 0);
    wait_resp(rd, re, rc);
    chk("b2b_first", 32'(rd), 'hC2);
    wait_resp(rd, re, rc);
    chk("b2b_second", 32'(rd), 'hC1);
    wait_resp(rd, re, rc);
    chk("b2b_third", 32'(rd), 'hC0);

    lat = 3;
    stall = 1'b1;
    send(1'b0, 1'b0, 8'h20, 8'h00, 1'b1);
    send(1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
    wait_resp(rd, re, rc);
    stall = 1'b0;
    chk("timeout_err", 32'(re), 1);
    chk("timeout_data", 32'(rd), 0);
    chk("timeout_cycles", 32'(rc - issue_cyc), 65);
    @(negedge clk);
    chk("timeout_err_clears", 32'(respError), 0);
    wait_resp(rd, re, rc);
    chk("after_timeout_data", 32'(rd), 'hE2);
    chk("after_timeout_err", 32'(re), 0);

    stall = 1'b1;
    send(1'b0, 1'b0, 8'h30, 8'h00, 1'b1);
    send(1'b0, 1'b0, 8'h31, 8'h00, 1'b1);
    repeat (5) @(negedge clk);
    chk("midrst_in_wait", 32'(memCntrl), 1);
    @(posedge clk);
    #1 clr = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_cntrl", 32'(memCntrl), 0);
    chk("midrst_ready", 32'(reqReady), 1);
    chk("midrst_valid", 32'(respValid), 0);
    chk("midrst_addr", 32'(memAddr), 0);
    clr = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_dropped", 32'({memCntrl != 2'b00, respValid}), 0);
    end
    send(1'b0, 1'b0, 8'h31, 8'h00, 1'b0);
    wait_resp(rd, re, rc);
    chk("midrst_new_data", 32'(rd), 'hF2);
    chk("midrst_new_err", 32'(re), 0);

    noise = 1'b1;
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(2, 8);
      send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
